// File: rtl/fetch_unit_pkg.sv
// Shared fetch/controller definitions: data and address widths, IR field layout,
// opcode encodings and the read FSM state type.
package fetch_unit_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 5;
  localparam int OPC_W   = 3;
  localparam int OPC_LSB = 5;
  localparam int OPC_MSB = OPC_LSB + OPC_W - 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [OPC_W-1:0]  opc_t;

  // Opcode encodings decoded by the controller from ir[7:5].
  typedef enum logic [OPC_W-1:0] {
    OP_HLT = 3'd0,
    OP_LDA = 3'd1,
    OP_STA = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_JMP = 3'd5,
    OP_JZ  = 3'd6,
    OP_NOP = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_HOLD = 2'd2
  } rd_state_e;

  function automatic opc_t ir_opcode(input data_t ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

  function automatic addr_t ir_operand(input data_t ir);
    return ir[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_mem_if.sv
// Memory read handshake: IDLE/WAIT/HOLD FSM with an ack timeout counter and a
// read buffer that holds the returned byte until the controller releases rd.
module fetch_mem_if
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rd,
  input  logic  halted,
  input  logic  mem_ack,
  input  data_t mem_data,
  output logic  mem_req,
  output logic  stall,
  output data_t rbuf,
  output logic  rbuf_valid,
  output logic  ack_err
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  rd_state_e        state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  data_t            rbuf_q, rbuf_d;
  logic             rbuf_valid_q, rbuf_valid_d;
  logic             ack_err_q, ack_err_d;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    cnt_d        = cnt_q;
    rbuf_d       = rbuf_q;
    rbuf_valid_d = rbuf_valid_q;
    ack_err_d    = ack_err_q;
    case (state_q)
      RD_IDLE: begin
        if (rd && !halted) begin
          state_d   = RD_WAIT;
          mem_req_d = 1'b1;
          cnt_d     = '0;
        end
      end
      RD_WAIT: begin
        // An ack arriving on the last allowed cycle still wins over the timeout.
        if (mem_ack) begin
          rbuf_d       = mem_data;
          rbuf_valid_d = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = RD_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          ack_err_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = RD_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_HOLD: begin
        if (!rd) begin
          state_d      = RD_IDLE;
          rbuf_valid_d = 1'b0;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RD_IDLE;
      mem_req_q    <= 1'b0;
      cnt_q        <= '0;
      rbuf_q       <= '0;
      rbuf_valid_q <= 1'b0;
      ack_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      cnt_q        <= cnt_d;
      rbuf_q       <= rbuf_d;
      rbuf_valid_q <= rbuf_valid_d;
      ack_err_q    <= ack_err_d;
    end
  end

  // Stall rises in the same cycle rd is raised so the controller freezes at once.
  assign stall      = (state_q == RD_WAIT) | ((state_q == RD_IDLE) & rd & !halted);
  assign mem_req    = mem_req_q;
  assign rbuf       = rbuf_q;
  assign rbuf_valid = rbuf_valid_q;
  assign ack_err    = ack_err_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, IR, address mux and halt status around the memory read FSM.
// Build option FETCH_WRAP_HALT_EN: an inc_pc that wraps PC 31 -> 0 also halts.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              rd,
  input  logic              ld_ir,
  input  logic              inc_pc,
  input  logic              ld_pc,
  input  logic              halt_in,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              stall,
  output logic              halted,
  output logic              ack_err
);

  addr_t pc_q, pc_d;
  data_t ir_q, ir_d;
  logic  halted_q, halted_d;
  data_t rbuf;
  logic  rbuf_valid;

  fetch_mem_if #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_mem_if (
    .clk       (clk),
    .rst       (rst),
    .rd        (rd),
    .halted    (halted_q),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .mem_req   (mem_req),
    .stall     (stall),
    .rbuf      (rbuf),
    .rbuf_valid(rbuf_valid),
    .ack_err   (ack_err)
  );

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    // Halt and stall freeze all architectural updates; halt_in still lets this
    // cycle's PC update land before halted takes effect.
    if (!halted_q && !stall) begin
      if (ld_ir && rbuf_valid) begin
        ir_d = rbuf;
      end
      if (ld_pc) begin
        pc_d = ir_operand(ir_q);
      end else if (inc_pc) begin
        pc_d = pc_q + ADDR_W'(1);
`ifdef FETCH_WRAP_HALT_EN
        if (pc_q == '1) begin
          halted_d = 1'b1;
        end
`endif
      end
      if (halt_in) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  assign mem_addr = sel ? pc_q : ir_operand(ir_q);
  assign opcode   = ir_opcode(ir_q);
  assign ir_addr  = ir_operand(ir_q);
  assign pc       = pc_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: read handshake, IR/PC updates, timeout, wrap, halt
// and reset-during-read, each against hand-computed expected values.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

`ifdef FETCH_WRAP_HALT_EN
  localparam logic WRAP_HALT = 1'b1;
`else
  localparam logic WRAP_HALT = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              sel, rd, ld_ir, inc_pc, ld_pc, halt_in, mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_addr, ir_addr, pc;
  logic [OPC_W-1:0]  opcode;
  logic              mem_req, stall, halted, ack_err;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit #(.ACK_TIMEOUT(15)) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .rd      (rd),
    .ld_ir   (ld_ir),
    .inc_pc  (inc_pc),
    .ld_pc   (ld_pc),
    .halt_in (halt_in),
    .mem_data(mem_data),
    .mem_ack (mem_ack),
    .mem_addr(mem_addr),
    .mem_req (mem_req),
    .opcode  (opcode),
    .ir_addr (ir_addr),
    .pc      (pc),
    .stall   (stall),
    .halted  (halted),
    .ack_err (ack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-16s got 0x%0h", tag, got);
    end else begin
      $display("FAIL %-16s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete read of byte d followed by an IR load; leaves the FSM in IDLE.
  task automatic do_read(input logic [7:0] d);
    rd = 1'b1;
    tick();
    mem_ack  = 1'b1;
    mem_data = d;
    tick();
    mem_ack = 1'b0;
    rd      = 1'b0;
    ld_ir   = 1'b1;
    tick();
    ld_ir = 1'b0;
  endtask

  int stall_n;
  int wait_n;

  initial begin
    rst = 1'b1; sel = 1'b0; rd = 1'b0; ld_ir = 1'b0; inc_pc = 1'b0;
    ld_pc = 1'b0; halt_in = 1'b0; mem_ack = 1'b0; mem_data = '0;
    #2;
    check("rst_pc",      32'(pc),      32'h0);
    check("rst_ir",      32'({opcode, ir_addr}), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_halted",  32'(halted),  32'h0);
    check("rst_ack_err", 32'(ack_err), 32'h0);
    check("rst_stall",   32'(stall),   32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Basic read: ack two cycles after mem_req, data 0xA3.
    sel = 1'b1; rd = 1'b1; stall_n = 0;
    #1;
    stall_n += int'(stall);
    check("rd_mem_addr",   32'(mem_addr), 32'h0);
    check("rd_req_before", 32'(mem_req),  32'h0);
    tick();
    stall_n += int'(stall);
    check("rd_req_up",     32'(mem_req),  32'h1);
    tick();
    mem_ack = 1'b1; mem_data = 8'hA3;
    #1;
    stall_n += int'(stall);
    tick();
    mem_ack = 1'b0; rd = 1'b0; ld_ir = 1'b1;
    #1;
    stall_n += int'(stall);
    check("rd_req_down",   32'(mem_req),  32'h0);
    tick();
    ld_ir = 1'b0;
    check("rd_stall_cyc",  32'(stall_n),  32'd3);
    check("rd_opcode",     32'(opcode),   32'd5);
    check("rd_ir_addr",    32'(ir_addr),  32'd3);

    // ld_pc beats inc_pc.
    do_read(8'h12);
    check("ir_addr_12",    32'(ir_addr),  32'h12);
    sel = 1'b0;
    #1;
    check("mux_ir",        32'(mem_addr), 32'h12);
    ld_pc = 1'b1; inc_pc = 1'b1;
    tick();
    ld_pc = 1'b0; inc_pc = 1'b0;
    check("ldpc_prio",     32'(pc),       32'h12);
    inc_pc = 1'b1;
    tick();
    inc_pc = 1'b0; sel = 1'b1;
    #1;
    check("inc_pc",        32'(pc),       32'h13);
    check("mux_pc",        32'(mem_addr), 32'h13);

    // Ack never arrives: timeout after 15 WAIT cycles.
    rd = 1'b1;
    tick();
    check("to_err_before", 32'(ack_err),  32'h0);
    wait_n = 0;
    while (stall && wait_n < 40) begin
      tick();
      wait_n++;
    end
    check("to_wait_cyc",   32'(wait_n),   32'd15);
    check("to_ack_err",    32'(ack_err),  32'h1);
    check("to_mem_req",    32'(mem_req),  32'h0);
    check("to_stall",      32'(stall),    32'h0);
    rd = 1'b0;
    tick();

    // PC wrap 31 -> 0.
    do_read(8'h1F);
    ld_pc = 1'b1;
    tick();
    ld_pc = 1'b0;
    check("pc_31",         32'(pc),       32'd31);
    inc_pc = 1'b1;
    tick();
    inc_pc = 1'b0;
    check("wrap_pc",       32'(pc),       32'd0);
    check("wrap_halted",   32'(halted),   32'(WRAP_HALT));

    // halt_in with inc_pc: PC moves then halted sets (unless already halted).
    halt_in = 1'b1; inc_pc = 1'b1;
    tick();
    halt_in = 1'b0; inc_pc = 1'b0;
    check("halt_set",      32'(halted),   32'h1);
    check("halt_inc_pc",   32'(pc),       WRAP_HALT ? 32'd0 : 32'd1);
    rd = 1'b1; ld_ir = 1'b1; inc_pc = 1'b1;
    #1;
    check("halt_no_stall", 32'(stall),    32'h0);
    tick();
    tick();
    check("halt_no_req",   32'(mem_req),  32'h0);
    check("halt_pc_hold",  32'(pc),       WRAP_HALT ? 32'd0 : 32'd1);
    check("halt_ir_hold",  32'({opcode, ir_addr}), 32'h1F);
    rd = 1'b0; ld_ir = 1'b0; inc_pc = 1'b0;

    // Reset during WAIT, then a late ack must be ignored.
    rst = 1'b1;
    tick();
    rst = 1'b0; rd = 1'b1;
    tick();
    check("rr_req_up",     32'(mem_req),  32'h1);
    #2;
    rst = 1'b1; rd = 1'b0;
    #1;
    check("rr_async_req",  32'(mem_req),  32'h0);
    tick();
    rst = 1'b0; mem_ack = 1'b1; mem_data = 8'hFF; ld_ir = 1'b1;
    tick();
    mem_ack = 1'b0; ld_ir = 1'b0;
    tick();
    check("rr_mem_req",    32'(mem_req),  32'h0);
    check("rr_stall",      32'(stall),    32'h0);
    check("rr_rbuf_valid", 32'(dut.u_mem_if.rbuf_valid_q), 32'h0);
    check("rr_ir",         32'({opcode, ir_addr}), 32'h0);
    check("rr_halted",     32'(halted),   32'h0);
    check("rr_ack_err",    32'(ack_err),  32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
